// File: rtl/oflow_score_board_pkg.sv
// rtl/oflow_score_board_pkg.sv - shared types and default sizing for the score board
package oflow_score_board_pkg;

  localparam int DEF_PE_NUM    = 8;
  localparam int DEF_ROWS      = 4;
  localparam int DEF_ROW_LEN   = 3;
  localparam int DEF_PE_LEN    = 4;
  localparam int DEF_SCORE_LEN = 11;
  localparam int DEF_ID_LEN    = 12;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_READY,
    ST_CLEAR
  } sb_state_e;

  typedef struct packed {
    logic                     valid;
    logic                     pointer;
    logic [DEF_SCORE_LEN-1:0] best_score;
    logic [DEF_ID_LEN-1:0]    best_id;
    logic [DEF_SCORE_LEN-1:0] fb_score;
    logic [DEF_ID_LEN-1:0]    fb_id;
  } sb_entry_t;

endpackage

// File: rtl/oflow_score_board_row.sv
// rtl/oflow_score_board_row.sv - one row of PE_NUM entries: fill write, pointer update, clear, read mux
module oflow_score_board_row
  import oflow_score_board_pkg::*;
#(
  parameter int PE_NUM    = DEF_PE_NUM,
  parameter int PE_LEN    = DEF_PE_LEN,
  parameter int SCORE_LEN = DEF_SCORE_LEN,
  parameter int ID_LEN    = DEF_ID_LEN
) (
  input  logic                 clk,
  input  logic                 reset_N,
  input  logic                 wr_en,
  input  logic [PE_LEN-1:0]    wr_pe,
  input  logic [SCORE_LEN-1:0] wr_best_score,
  input  logic [ID_LEN-1:0]    wr_best_id,
  input  logic [SCORE_LEN-1:0] wr_fb_score,
  input  logic [ID_LEN-1:0]    wr_fb_id,
  input  logic                 ptr_en,
  input  logic [PE_LEN-1:0]    ptr_pe,
  input  logic                 ptr_val,
  input  logic                 clr,
  input  logic [PE_LEN-1:0]    rd_pe,
  output logic [SCORE_LEN-1:0] rd_score,
  output logic [ID_LEN-1:0]    rd_id,
  output logic                 wr_slot_free,
  output logic                 ptr_rise
);

  sb_entry_t ent [PE_NUM];

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      for (int p = 0; p < PE_NUM; p++) ent[p] <= '0;
    end else begin
      for (int p = 0; p < PE_NUM; p++) begin
        if (clr) begin
          ent[p] <= '0;
        end else if (wr_en && wr_pe == PE_LEN'(p)) begin
          ent[p].valid      <= 1'b1;
          ent[p].pointer    <= 1'b0;
          ent[p].best_score <= wr_best_score;
          ent[p].best_id    <= wr_best_id;
          ent[p].fb_score   <= wr_fb_score;
          ent[p].fb_id      <= wr_fb_id;
        end else if (ptr_en && ptr_pe == PE_LEN'(p)) begin
          ent[p].pointer <= ptr_val;
        end
      end
    end
  end

  // Indices past PE_NUM never match a slot, so they read as empty and write nothing.
  always_comb begin
    rd_score     = '0;
    rd_id        = '0;
    wr_slot_free = 1'b0;
    ptr_rise     = 1'b0;
    for (int p = 0; p < PE_NUM; p++) begin
      if (rd_pe == PE_LEN'(p) && ent[p].valid) begin
        rd_score = ent[p].pointer ? ent[p].fb_score : ent[p].best_score;
        rd_id    = ent[p].pointer ? ent[p].fb_id    : ent[p].best_id;
      end
      if (wr_pe == PE_LEN'(p)) wr_slot_free = !ent[p].valid;
      if (ptr_pe == PE_LEN'(p)) ptr_rise = !ent[p].pointer && ptr_val;
    end
  end

endmodule

// File: rtl/oflow_score_board.sv
// rtl/oflow_score_board.sv - per-frame PE match score board; FSM, fill/clear counters, row array
// Optional demote counter output enabled by OFLOW_SCORE_BOARD_DEMOTE_CNT_EN.
module oflow_score_board
  import oflow_score_board_pkg::*;
#(
  parameter int PE_NUM    = DEF_PE_NUM,
  parameter int ROWS      = DEF_ROWS,
  parameter int ROW_LEN   = DEF_ROW_LEN,
  parameter int PE_LEN    = DEF_PE_LEN,
  parameter int SCORE_LEN = DEF_SCORE_LEN,
  parameter int ID_LEN    = DEF_ID_LEN
) (
  input  logic                       clk,
  input  logic                       reset_N,
  input  logic                       frame_start,
  input  logic [ROW_LEN+PE_LEN-1:0]  num_entries,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [ROW_LEN-1:0]         wr_row,
  input  logic [PE_LEN-1:0]          wr_pe,
  input  logic [SCORE_LEN-1:0]       wr_best_score,
  input  logic [ID_LEN-1:0]          wr_best_id,
  input  logic [SCORE_LEN-1:0]       wr_fb_score,
  input  logic [ID_LEN-1:0]          wr_fb_id,
  output logic                       start_cr,
  input  logic                       done_cr,
  input  logic                       csb,
  input  logic [ROW_LEN-1:0]         row_sel,
  input  logic [PE_LEN-1:0]          pe_sel,
  output logic [SCORE_LEN-1:0]       score_to_cr,
  output logic [ID_LEN-1:0]          id_to_cr,
  input  logic                       write_to_pointer,
  input  logic [ROW_LEN-1:0]         row_to_change,
  input  logic [PE_LEN-1:0]          pe_to_change,
  input  logic                       data_to_score_board,
  output logic                       sb_busy
`ifdef OFLOW_SCORE_BOARD_DEMOTE_CNT_EN
  ,
  output logic [ROW_LEN+PE_LEN-1:0]  demote_count
`endif
);

  localparam int CNT_W = ROW_LEN + PE_LEN;
  localparam int TOTAL = ROWS * PE_NUM;

  sb_state_e            state_q, state_d;
  logic [CNT_W-1:0]     fill_cnt_q;
  logic [CNT_W-1:0]     target_q;
  logic [ROW_LEN-1:0]   clr_row_q;
  logic                 start_cr_q;
  logic                 accept;
  logic                 slot_new;
  logic                 ptr_rise_sel;

  logic [ROWS-1:0]      row_wr_en;
  logic [ROWS-1:0]      row_ptr_en;
  logic [ROWS-1:0]      row_clr;
  logic [ROWS-1:0]      row_free;
  logic [ROWS-1:0]      row_rise;
  logic [SCORE_LEN-1:0] row_score [ROWS];
  logic [ID_LEN-1:0]    row_id    [ROWS];

  always_comb begin
    state_d  = state_q;
    wr_ready = 1'b0;
    sb_busy  = 1'b1;
    case (state_q)
      ST_IDLE: begin
        sb_busy = 1'b0;
        if (frame_start) state_d = ST_FILL;
      end
      ST_FILL: begin
        wr_ready = 1'b1;
        if (fill_cnt_q == target_q) state_d = ST_READY;
      end
      ST_READY: begin
        if (done_cr) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        if (clr_row_q == ROW_LEN'(ROWS - 1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign accept   = wr_valid && wr_ready;
  assign start_cr = start_cr_q;

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state_q    <= ST_IDLE;
      fill_cnt_q <= '0;
      target_q   <= '0;
      clr_row_q  <= '0;
      start_cr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_cr_q <= (state_q == ST_FILL) && (state_d == ST_READY);
      if (state_q == ST_IDLE && frame_start) begin
        fill_cnt_q <= '0;
        target_q   <= (num_entries > CNT_W'(TOTAL)) ? CNT_W'(TOTAL) : num_entries;
      end else if (accept && slot_new) begin
        // Overwrites of an already-filled slot do not advance the count.
        fill_cnt_q <= fill_cnt_q + CNT_W'(1);
      end
      if (state_q == ST_CLEAR && clr_row_q != ROW_LEN'(ROWS - 1)) begin
        clr_row_q <= clr_row_q + ROW_LEN'(1);
      end else begin
        clr_row_q <= '0;
      end
    end
  end

`ifdef OFLOW_SCORE_BOARD_DEMOTE_CNT_EN
  logic [CNT_W-1:0] demote_q;

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      demote_q <= '0;
    end else if (state_q == ST_IDLE && frame_start) begin
      demote_q <= '0;
    end else if (state_q == ST_READY && write_to_pointer && ptr_rise_sel && demote_q != '1) begin
      demote_q <= demote_q + CNT_W'(1);
    end
  end

  assign demote_count = demote_q;
`endif

  // Row selection by comparison: out-of-range row indices simply match nothing.
  always_comb begin
    slot_new     = 1'b0;
    ptr_rise_sel = 1'b0;
    score_to_cr  = '0;
    id_to_cr     = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (wr_row == ROW_LEN'(r)) slot_new = row_free[r];
      if (row_to_change == ROW_LEN'(r)) ptr_rise_sel = row_rise[r];
      if (!csb && row_sel == ROW_LEN'(r)) begin
        score_to_cr = row_score[r];
        id_to_cr    = row_id[r];
      end
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    assign row_wr_en[r]  = accept && (wr_row == ROW_LEN'(r));
    assign row_ptr_en[r] = (state_q == ST_READY) && write_to_pointer && (row_to_change == ROW_LEN'(r));
    assign row_clr[r]    = (state_q == ST_CLEAR) && (clr_row_q == ROW_LEN'(r));

    oflow_score_board_row #(
      .PE_NUM    (PE_NUM),
      .PE_LEN    (PE_LEN),
      .SCORE_LEN (SCORE_LEN),
      .ID_LEN    (ID_LEN)
    ) u_row (
      .clk           (clk),
      .reset_N       (reset_N),
      .wr_en         (row_wr_en[r]),
      .wr_pe         (wr_pe),
      .wr_best_score (wr_best_score),
      .wr_best_id    (wr_best_id),
      .wr_fb_score   (wr_fb_score),
      .wr_fb_id      (wr_fb_id),
      .ptr_en        (row_ptr_en[r]),
      .ptr_pe        (pe_to_change),
      .ptr_val       (data_to_score_board),
      .clr           (row_clr[r]),
      .rd_pe         (pe_sel),
      .rd_score      (row_score[r]),
      .rd_id         (row_id[r]),
      .wr_slot_free  (row_free[r]),
      .ptr_rise      (row_rise[r])
    );
  end

endmodule

// File: tb/tb_oflow_score_board.sv
// tb/tb_oflow_score_board.sv - directed self-checking bench for oflow_score_board
module tb_oflow_score_board;

  logic        clk;
  logic        reset_N;
  logic        frame_start;
  logic [6:0]  num_entries;
  logic        wr_valid;
  logic        wr_ready;
  logic [2:0]  wr_row;
  logic [3:0]  wr_pe;
  logic [10:0] wr_best_score;
  logic [11:0] wr_best_id;
  logic [10:0] wr_fb_score;
  logic [11:0] wr_fb_id;
  logic        start_cr;
  logic        done_cr;
  logic        csb;
  logic [2:0]  row_sel;
  logic [3:0]  pe_sel;
  logic [10:0] score_to_cr;
  logic [11:0] id_to_cr;
  logic        write_to_pointer;
  logic [2:0]  row_to_change;
  logic [3:0]  pe_to_change;
  logic        data_to_score_board;
  logic        sb_busy;
`ifdef OFLOW_SCORE_BOARD_DEMOTE_CNT_EN
  logic [6:0]  demote_count;
`endif

  int checks = 0;
  int errors = 0;

  oflow_score_board dut (
    .clk                 (clk),
    .reset_N             (reset_N),
    .frame_start         (frame_start),
    .num_entries         (num_entries),
    .wr_valid            (wr_valid),
    .wr_ready            (wr_ready),
    .wr_row              (wr_row),
    .wr_pe               (wr_pe),
    .wr_best_score       (wr_best_score),
    .wr_best_id          (wr_best_id),
    .wr_fb_score         (wr_fb_score),
    .wr_fb_id            (wr_fb_id),
    .start_cr            (start_cr),
    .done_cr             (done_cr),
    .csb                 (csb),
    .row_sel             (row_sel),
    .pe_sel              (pe_sel),
    .score_to_cr         (score_to_cr),
    .id_to_cr            (id_to_cr),
    .write_to_pointer    (write_to_pointer),
    .row_to_change       (row_to_change),
    .pe_to_change        (pe_to_change),
    .data_to_score_board (data_to_score_board),
    .sb_busy             (sb_busy)
`ifdef OFLOW_SCORE_BOARD_DEMOTE_CNT_EN
    ,
    .demote_count        (demote_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One full clock period: inputs change and outputs are sampled at the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] r, input logic [3:0] p, input logic [10:0] bs,
                    input logic [11:0] bid, input logic [10:0] fs, input logic [11:0] fid);
    wr_valid = 1'b1; wr_row = r; wr_pe = p;
    wr_best_score = bs; wr_best_id = bid; wr_fb_score = fs; wr_fb_id = fid;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic rd(input logic c, input logic [2:0] r, input logic [3:0] p);
    csb = c; row_sel = r; pe_sel = p;
    #1;
  endtask

  task automatic start_frame(input logic [6:0] n);
    frame_start = 1'b1; num_entries = n;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic finish_frame();
    done_cr = 1'b1;
    tick();
    done_cr = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    reset_N = 1'b0; frame_start = 1'b0; num_entries = '0;
    wr_valid = 1'b0; wr_row = '0; wr_pe = '0;
    wr_best_score = '0; wr_best_id = '0; wr_fb_score = '0; wr_fb_id = '0;
    done_cr = 1'b0; csb = 1'b0; row_sel = '0; pe_sel = '0;
    write_to_pointer = 1'b0; row_to_change = '0; pe_to_change = '0; data_to_score_board = 1'b0;
    tick();
    tick();
    rd(1'b0, 3'd0, 4'd0);
    chk("reset_wr_ready", 32'(wr_ready), 0);
    chk("reset_start_cr", 32'(start_cr), 0);
    chk("reset_busy", 32'(sb_busy), 0);
    chk("reset_id", 32'(id_to_cr), 0);
    reset_N = 1'b1;
    tick();

    // Basic fill of three entries
    start_frame(7'd3);
    chk("fill_busy", 32'(sb_busy), 1);
    chk("fill_wr_ready", 32'(wr_ready), 1);
    wr(3'd0, 4'd0, 11'd100, 12'd1, 11'd50, 12'd11);
    wr(3'd0, 4'd1, 11'd200, 12'd2, 11'd60, 12'd12);
    wr(3'd1, 4'd0, 11'd300, 12'd3, 11'd70, 12'd13);
    chk("fill_no_start_yet", 32'(start_cr), 0);
    tick();
    chk("fill_start_pulse", 32'(start_cr), 1);
    chk("ready_wr_ready", 32'(wr_ready), 0);
    rd(1'b0, 3'd0, 4'd1);
    chk("read01_score", 32'(score_to_cr), 200);
    chk("read01_id", 32'(id_to_cr), 2);
    rd(1'b0, 3'd2, 4'd0);
    chk("read20_empty", 32'(id_to_cr), 0);
    tick();
    chk("start_one_cycle", 32'(start_cr), 0);

    // Pointer demote: same-cycle read shows the old value
    write_to_pointer = 1'b1; row_to_change = 3'd1; pe_to_change = 4'd0; data_to_score_board = 1'b1;
    rd(1'b0, 3'd1, 4'd0);
    chk("demote_same_cycle_id", 32'(id_to_cr), 3);
    tick();
    write_to_pointer = 1'b0;
    #1;
    chk("demote_next_id", 32'(id_to_cr), 13);
    chk("demote_next_score", 32'(score_to_cr), 70);
`ifdef OFLOW_SCORE_BOARD_DEMOTE_CNT_EN
    chk("demote_count_1", 32'(demote_count), 1);
`endif

    // Out-of-range and chip select
    rd(1'b0, 3'd4, 4'd0);
    chk("row_oob", 32'(id_to_cr), 0);
    rd(1'b0, 3'd0, 4'd8);
    chk("pe_oob", 32'(id_to_cr), 0);
    rd(1'b1, 3'd0, 4'd0);
    chk("csb_high", 32'(id_to_cr), 0);
    rd(1'b0, 3'd0, 4'd0);
    chk("csb_low", 32'(id_to_cr), 1);

    // Writes are ignored in READY
    wr(3'd2, 4'd2, 11'd9, 12'd99, 11'd9, 12'd98);
    rd(1'b0, 3'd2, 4'd2);
    chk("ready_write_ignored", 32'(id_to_cr), 0);

    // Clear sweep: busy for ROWS cycles after done_cr
    done_cr = 1'b1;
    tick();
    done_cr = 1'b0;
    wr_valid = 1'b1; wr_row = 3'd3; wr_pe = 4'd3; wr_best_id = 12'd77;
    #1;
    chk("clear_wr_ready", 32'(wr_ready), 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("clear_busy_%0d", i), 32'(sb_busy), 1);
      tick();
    end
    wr_valid = 1'b0;
    chk("clear_done_idle", 32'(sb_busy), 0);
    rd(1'b0, 3'd0, 4'd0);
    chk("cleared_00", 32'(id_to_cr), 0);
    rd(1'b0, 3'd1, 4'd0);
    chk("cleared_10", 32'(id_to_cr), 0);
    rd(1'b0, 3'd3, 4'd3);
    chk("cleared_33", 32'(id_to_cr), 0);
`ifdef OFLOW_SCORE_BOARD_DEMOTE_CNT_EN
    chk("demote_held", 32'(demote_count), 1);
`endif

    // Overwrite does not count toward the target
    start_frame(7'd2);
`ifdef OFLOW_SCORE_BOARD_DEMOTE_CNT_EN
    chk("demote_cleared", 32'(demote_count), 0);
`endif
    wr(3'd0, 4'd0, 11'd5, 12'd21, 11'd6, 12'd31);
    wr(3'd0, 4'd0, 11'd7, 12'd22, 11'd8, 12'd32);
    tick();
    chk("overwrite_no_start", 32'(start_cr), 0);
    chk("overwrite_still_fill", 32'(wr_ready), 1);
    wr(3'd0, 4'd1, 11'd9, 12'd23, 11'd10, 12'd33);
    tick();
    chk("overwrite_start", 32'(start_cr), 1);
    rd(1'b0, 3'd0, 4'd0);
    chk("overwrite_score", 32'(score_to_cr), 7);
    chk("overwrite_id", 32'(id_to_cr), 22);
    finish_frame();

    // Zero-entry frame goes straight to READY
    start_frame(7'd0);
    chk("zero_fill_no_start", 32'(start_cr), 0);
    tick();
    chk("zero_start", 32'(start_cr), 1);
    finish_frame();
    chk("zero_idle", 32'(sb_busy), 0);

    // Reset mid-FILL
    start_frame(7'd5);
    wr(3'd0, 4'd0, 11'd1, 12'd41, 11'd1, 12'd51);
    wr(3'd0, 4'd1, 11'd2, 12'd42, 11'd2, 12'd52);
    #2;
    reset_N = 1'b0;
    #1;
    rd(1'b0, 3'd0, 4'd0);
    chk("midreset_busy", 32'(sb_busy), 0);
    chk("midreset_wr_ready", 32'(wr_ready), 0);
    chk("midreset_start", 32'(start_cr), 0);
    chk("midreset_id", 32'(id_to_cr), 0);
    tick();
    reset_N = 1'b1;
    tick();
    start_frame(7'd5);
    wr(3'd0, 4'd0, 11'd1, 12'd41, 11'd1, 12'd51);
    wr(3'd0, 4'd1, 11'd2, 12'd42, 11'd2, 12'd52);
    wr(3'd0, 4'd2, 11'd3, 12'd43, 11'd3, 12'd53);
    wr(3'd1, 4'd1, 11'd4, 12'd44, 11'd4, 12'd54);
    tick();
    chk("refill_4_no_start", 32'(start_cr), 0);
    wr(3'd3, 4'd7, 11'd1234, 12'd4000, 11'd5, 12'd55);
    chk("refill_5_no_start", 32'(start_cr), 0);
    tick();
    chk("refill_start", 32'(start_cr), 1);
    rd(1'b0, 3'd3, 4'd7);
    chk("refill_37_score", 32'(score_to_cr), 1234);
    chk("refill_37_id", 32'(id_to_cr), 4000);
    finish_frame();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
